// File: rtl/agnus_clk_pkg.sv
// Shared phase type, strobe phase constants and clock/strobe decode helpers
// for the Agnus C28M phase generator.
package agnus_clk_pkg;

  typedef logic [2:0] phase_t;

  localparam phase_t PH_RESET      = 3'd0;
  localparam phase_t PH_C7M_RISE_A = 3'd3;
  localparam phase_t PH_C7M_RISE_B = 3'd7;
  localparam phase_t PH_CCK_FALL   = 3'd3;
  localparam phase_t PH_CCK_RISE   = 3'd7;

  localparam int LINE_LEN_PAL = 227;

  typedef struct packed {
    logic c14m;
    logic c7m;
    logic cdac;
    logic cck;
    logic cckq;
  } clk_vec_t;

  typedef struct packed {
    logic c7m_rise;
    logic cck_rise;
    logic cck_fall;
  } stb_vec_t;

  // Clock levels seen while the counter holds phase k.
  function automatic clk_vec_t decode_clk(phase_t k);
    clk_vec_t v;
    v.c14m = ~k[0];
    v.c7m  = ~k[1];
    v.cdac = k[1] ^ k[0];
    v.cck  = ~k[2];
    v.cckq = k[2] ^ k[1];
    return v;
  endfunction

  // Strobes are high on the phase just before the matching clock edge.
  function automatic stb_vec_t decode_stb(phase_t k);
    stb_vec_t s;
    s.c7m_rise = (k == PH_C7M_RISE_A) || (k == PH_C7M_RISE_B);
    s.cck_rise = (k == PH_CCK_RISE);
    s.cck_fall = (k == PH_CCK_FALL);
    return s;
  endfunction

endpackage

// File: rtl/agnus_hslot_cnt.sv
// Colour-clock slot counter: HCNT, LINE_STB and the NTSC long/short line
// flag, advanced once per CCK period by the CCK rise strobe.
module agnus_hslot_cnt
  import agnus_clk_pkg::*;
#(
  parameter int LINE_LEN   = LINE_LEN_PAL,
  parameter int HCNT_W     = 8,
  parameter int LONG_EXTRA = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              resync,
  input  logic              ntsc,
  output logic [HCNT_W-1:0] hcnt,
  output logic              line_stb,
  output logic              lol
);

  localparam logic [HCNT_W-1:0] LAST_SHORT = HCNT_W'(LINE_LEN - 1);
  localparam logic [HCNT_W-1:0] LAST_LONG  = HCNT_W'(LINE_LEN + LONG_EXTRA - 1);

  logic [HCNT_W-1:0] hcnt_next;
  logic              stb_next;
  logic              lol_next;
  logic              wrap;

  assign wrap = adv && (hcnt == (lol ? LAST_LONG : LAST_SHORT));

  // A resync landing on a natural wrap is absorbed by the wrap, so the line
  // still produces a single LINE_STB and LOL advances normally.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    hcnt_next = hcnt;
    stb_next  = 1'b0;
    lol_next  = lol;
    if (wrap) begin
      hcnt_next = '0;
      stb_next  = 1'b1;
      lol_next  = ntsc ? ~lol : 1'b0;
    end else if (resync) begin
      hcnt_next = '0;
      stb_next  = 1'b1;
    end else if (adv) begin
      hcnt_next = hcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt     <= '0;
      line_stb <= 1'b0;
      lol      <= 1'b0;
    end else begin
      hcnt     <= hcnt_next;
      line_stb <= stb_next;
      lol      <= lol_next;
    end
  end

endmodule

// File: rtl/agnus_clk_phase_gen.sv
// Agnus clock phase generator: one 3-bit C28M phase counter decoded into
// registered C14M/C7M/CDAC/CCK/CCKQ, clock-enable strobes and the CCK slot
// counter. Define CLK_PHASE_SYNC_EN to add the SYNCn genlock resync input.
module agnus_clk_phase_gen
  import agnus_clk_pkg::*;
#(
  parameter int LINE_LEN   = LINE_LEN_PAL,
  parameter int HCNT_W     = 8,
  parameter int LONG_EXTRA = 1
) (
  input  logic              C28M,
  input  logic              RESETn,
  input  logic              NTSC,
`ifdef CLK_PHASE_SYNC_EN
  input  logic              SYNCn,
`endif
  output logic              C14M,
  output logic              C7M,
  output logic              CDAC,
  output logic              CCK,
  output logic              CCKQ,
  output logic [2:0]        PH,
  output logic              C7M_RISE_EN,
  output logic              CCK_RISE_EN,
  output logic              CCK_FALL_EN,
  output logic [HCNT_W-1:0] HCNT,
  output logic              LINE_STB,
  output logic              LOL
);

  phase_t   ph_q;
  phase_t   ph_next;
  clk_vec_t clk_q;
  stb_vec_t stb_q;
  logic     resync;

`ifdef CLK_PHASE_SYNC_EN
  // Two flops resolve metastability; the third holds the previous level for edge detection.
  // NOTE: the synchroniser is deliberately not reset: it only mirrors SYNCn, and forcing it high
  // would fabricate a falling edge right after reset whenever SYNCn is held low.
  logic [2:0] sync_sr;

  always_ff @(posedge C28M) begin
    sync_sr <= {sync_sr[1:0], SYNCn};
  end

  assign resync = sync_sr[2] & ~sync_sr[1];
`else
  assign resync = 1'b0;
`endif

  always_comb begin
    ph_next = ph_q + 3'd1;
    if (resync) ph_next = PH_RESET;
  end

  // Outputs decode ph_next so their registered values line up with PH.
  always_ff @(posedge C28M) begin
    // NOTE: state registers use non-blocking assignments so each flop samples pre-edge values.
    if (!RESETn) begin
      ph_q  <= PH_RESET;
      clk_q <= decode_clk(PH_RESET);
      stb_q <= '0;
    end else begin
      ph_q  <= ph_next;
      clk_q <= decode_clk(ph_next);
      stb_q <= decode_stb(ph_next);
    end
  end

  agnus_hslot_cnt #(
    .LINE_LEN   (LINE_LEN),
    .HCNT_W     (HCNT_W),
    .LONG_EXTRA (LONG_EXTRA)
  ) u_hslot (
    .clk      (C28M),
    .rst_n    (RESETn),
    .adv      (stb_q.cck_rise),
    .resync   (resync),
    .ntsc     (NTSC),
    .hcnt     (HCNT),
    .line_stb (LINE_STB),
    .lol      (LOL)
  );

  assign PH          = ph_q;
  assign C14M        = clk_q.c14m;
  assign C7M         = clk_q.c7m;
  assign CDAC        = clk_q.cdac;
  assign CCK         = clk_q.cck;
  assign CCKQ        = clk_q.cckq;
  assign C7M_RISE_EN = stb_q.c7m_rise;
  assign CCK_RISE_EN = stb_q.cck_rise;
  assign CCK_FALL_EN = stb_q.cck_fall;

endmodule
